z_sdpram_rd_stream: RTL
=======================

Name: z_sdpram_rd_stream

Overview:
- Read-side streamer that sits directly downstream of the simple dual-port RAM.
- Accepts a burst command (base address, length) and issues sequential reads on the RAM read port.
- Compensates for the RAM's fixed read latency and its ena_r-gated output pipeline.
- Delivers the read data as a valid/ready stream with a last flag to the consuming datapath (e.g. the systolic array feeder).

Parameters:
- ADDR_WIDTH, 8, RAM address width; must match the RAM instance.
- DATA_WIDTH, 128, RAM word and stream beat width.
- DEPTH, 192, RAM word count; ADDR_WIDTH >= clog2(DEPTH).
- LATENCY, 2, RAM read latency in cycles; must be >= 1 and equal to the RAM's LATENCY.
- LEN_WIDTH, 9, burst length field width.
- FIFO_DEPTH, 4, output buffer entries; must be >= LATENCY+2 for full throughput.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_base  in  ADDR_WIDTH  first read address
- cmd_len  in  LEN_WIDTH  number of beats; 0 = no-op
- ram_ena_r  out  1  to RAM ena_r
- ram_addr_r  out  ADDR_WIDTH  to RAM addr_r
- ram_dout  in  DATA_WIDTH  from RAM dout
- m_valid  out  1  stream beat valid
- m_ready  in  1  stream beat accepted when m_valid & m_ready
- m_data  out  DATA_WIDTH  beat data
- m_last  out  1  final beat of the burst; qualified by m_valid
- busy  out  1  high when state != IDLE

Behaviour:
- Reset:
  - rst_n is asynchronous and active-low; it clears the FSM, counters, the valid pipe and the FIFO.
  - Reset values: cmd_ready=1, ram_ena_r=0, ram_addr_r=0, m_valid=0, m_last=0, m_data=0, busy=0.
  - Assertion mid-burst abandons the burst; no further beats are emitted.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: cmd_ready=1. On handshake, latch addr=cmd_base and rem=cmd_len. Go to RUN if cmd_len!=0; otherwise stay in IDLE (no beats, no m_last).
  - RUN: issue a read when rem!=0 and (inflight + fifo_count) < FIFO_DEPTH. inflight counts reads issued but not yet written into the FIFO.
  - On each issue: ram_addr_r=addr, addr=addr+1 (ADDR_WIDTH wrap by default), rem=rem-1. After the final issue, go to DRAIN.
  - DRAIN: wait until inflight==0, FIFO empty, and the last beat has been handshaken, then go to IDLE.
  - cmd_ready is high only in IDLE. Back-to-back bursts are therefore separated by at least one IDLE cycle.
- RAM pipeline rule:
  - The RAM output pipeline advances only while ena_r=1.
  - ram_ena_r is held 1 whenever state!=IDLE, so in-flight data advances every cycle independent of issue.
  - Cycles with ena_r=1 but no issue produce don't-care data that is never captured.
- Valid tracking:
  - A LATENCY-deep shift register of issue flags, plus a last flag per stage.
  - ram_dout is written into the FIFO in the cycle the tail flag is set; the data was issued exactly LATENCY cycles earlier.
- FIFO:
  - Registered FIFO of FIFO_DEPTH entries {data, last}.
  - m_valid = FIFO non-empty; m_data/m_last = head entry.
  - Simultaneous push and pop in the same cycle is legal, including on a full or empty FIFO when the credit rule permits.
  - The credit rule guarantees the FIFO never overflows; overflow is a design error, enforced by an assertion.
- Timing:
  - Command handshake in cycle 0 → first issue in cycle 1 → first m_valid in cycle LATENCY+2.
  - With m_ready=1 and FIFO_DEPTH >= LATENCY+2: one beat per cycle.
  - Under backpressure, issue stops once inflight+fifo_count reaches FIFO_DEPTH and resumes the cycle after a pop frees a credit.
- m_last is set on the beat carrying the read of address base+len-1, exactly once per non-zero burst.

Optional Feature:
- Macro: Z_SDPRAM_RD_STREAM_WRAP_EN
- Defined: the read address wraps modulo DEPTH (DEPTH-1 → 0), supporting circular buffers in non-power-of-two RAMs. cmd_base >= DEPTH is clamped to 0.
- Undefined: the address wraps modulo 2^ADDR_WIDTH and no clamping is applied.

Test Plan:
- Basic burst, LATENCY=2: cmd base=0x10, len=4, m_ready=1 → m_valid in cycles 4..7; data = RAM[0x10..0x13]; m_last only in cycle 7; busy falls after the last handshake.
- Backpressure: len=8, m_ready low for 6 cycles after the first beat → issue stalls at inflight+fifo_count=4; no lost or duplicated beats; order preserved; exactly one m_last.
- Zero length: cmd len=0 → cmd_ready stays 1, busy stays 0, m_valid never asserted.
- Wrap with Z_SDPRAM_RD_STREAM_WRAP_EN: base=190, len=4, DEPTH=192 → addresses 190, 191, 0, 1. Without the macro → 190, 191, 192, 193.
- Reset mid-burst: rst_n low during beat 3 of 8 → all outputs return to reset values immediately. A new cmd (base=0, len=2) after release completes correctly with no stale beats.
- Random m_ready at 50%, 20 bursts of random base/len → a scoreboard matches every beat and m_last against a RAM model; the FIFO never overflows.

Source files
------------

// File: rtl/z_sdpram_rd_stream.sv
// Burst read streamer for the simple dual-port RAM read port: issues sequential reads,
// tracks the RAM read latency and buffers beats into a valid/ready stream with a last flag.
// Optional feature macro: Z_SDPRAM_RD_STREAM_WRAP_EN (wrap addresses modulo DEPTH, clamp bad bases).

module z_sdpram_rd_stream #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 192,
  parameter int LATENCY    = 2,
  parameter int LEN_WIDTH  = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_ena_r,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LATENCY-1:0]    vld_q, lst_q;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] fdata_q [FIFO_DEPTH];
  logic                  flast_q [FIFO_DEPTH];
  logic [CNT_W:0]        credit_used;
  logic                  issue, push, pop, drain_done;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef Z_SDPRAM_RD_STREAM_WRAP_EN
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
`else
    return a + ADDR_WIDTH'(1);
`endif
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] start_addr(input logic [ADDR_WIDTH-1:0] a);
`ifdef Z_SDPRAM_RD_STREAM_WRAP_EN
    return (32'(a) >= DEPTH) ? '0 : a;
`else
    return a;
`endif
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Every issued read holds a FIFO slot until popped, so the FIFO can never overflow.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign push        = vld_q[LATENCY-1];
  assign m_valid     = (count_q != '0);
  assign pop         = m_valid && m_ready;
  assign m_data      = fdata_q[rptr_q];
  assign m_last      = flast_q[rptr_q] && m_valid;
  assign ram_addr_r  = addr_q;
  assign ram_ena_r   = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign drain_done  = (inflight_q == '0) &&
                       ((count_q == '0) || ((count_q == CNT_W'(1)) && pop));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    issue     = 1'b0;
    cmd_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = start_addr(cmd_base);
          rem_d  = cmd_len;
          if (cmd_len != '0) state_d = RUN;
        end
      end
      RUN: begin
        if ((rem_q != '0) && (credit_used < (CNT_W+1)'(FIFO_DEPTH))) begin
          issue  = 1'b1;
          addr_d = next_addr(addr_q);
          rem_d  = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
      lst_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      // Issue flags march alongside the RAM pipeline, which advances every busy cycle.
      vld_q[0]   <= issue;
      lst_q[0]   <= issue && (rem_q == LEN_WIDTH'(1));
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fdata_q[i] <= '0;
        flast_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        fdata_q[wptr_q] <= ram_dout;
        flast_q[wptr_q] <= lst_q[LATENCY-1];
        wptr_q          <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
      assert (ADDR_WIDTH >= $clog2(DEPTH));
    end
  end

endmodule
